l15_vc_evict_buffer: RTL and testbench

//  Small FIFO between the L1.5 S3 eviction path and the victim cache fill port. Decouples the eviction

---
 rtl/l15_vc_evict_buffer_pkg.sv | 23 ++
 rtl/l15_vc_evict_cam.sv | 53 +++++
 rtl/l15_vc_evict_buffer.sv | 156 +++++++++++++++
 tb/tb_l15_vc_evict_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l15_vc_evict_buffer_pkg.sv
// Shared L1.5 definitions for the victim-cache eviction buffer: line geometry,
// MESI encodings and the eviction-state helper.
package l15_vc_evict_buffer_pkg;

  localparam int VC_ADDR_WIDTH       = 36;
  localparam int L15_CACHELINE_WIDTH = 128;

  typedef enum logic [1:0] {
    L15_MESI_I = 2'b00,
    L15_MESI_S = 2'b01,
    L15_MESI_E = 2'b10,
    L15_MESI_M = 2'b11
  } l15_mesi_e;

  localparam logic [1:0] L15_MESI_STATE_E = L15_MESI_E;
  localparam logic [1:0] L15_MESI_STATE_M = L15_MESI_M;

  // An evicted line arrives in the victim cache as M if it was dirty, else E.
  function automatic logic [1:0] evict_mesi(input logic dirty);
    return dirty ? L15_MESI_STATE_M : L15_MESI_STATE_E;
  endfunction

endpackage

// File: rtl/l15_vc_evict_cam.sv
// Address CAM for the eviction buffer: one compare per entry per port
// (enq, probe, squash) plus youngest-first selection for enq and probe.
module l15_vc_evict_cam
  import l15_vc_evict_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = VC_ADDR_WIDTH,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic [DEPTH*ADDR_WIDTH-1:0] i_addr_flat,
  input  logic [DEPTH-1:0]            i_live,
  input  logic [DEPTH-1:0]            i_enq_excl,
  input  logic [PTR_W-1:0]            i_tail,
  input  logic [ADDR_WIDTH-1:0]       i_enq_addr,
  input  logic [ADDR_WIDTH-1:0]       i_probe_addr,
  input  logic [ADDR_WIDTH-1:0]       i_squash_addr,
  output logic                        o_enq_hit,
  output logic [PTR_W-1:0]            o_enq_idx,
  output logic                        o_probe_hit,
  output logic [PTR_W-1:0]            o_probe_idx,
  output logic [DEPTH-1:0]            o_squash_vec
);

  logic [DEPTH-1:0] w_enq_vec;
  logic [DEPTH-1:0] w_probe_vec;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      logic [ADDR_WIDTH-1:0] w_entry_addr;
      assign w_entry_addr     = i_addr_flat[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_enq_vec[gi]    = i_live[gi] & ~i_enq_excl[gi] & (w_entry_addr == i_enq_addr);
      assign w_probe_vec[gi]  = i_live[gi] & (w_entry_addr == i_probe_addr);
      assign o_squash_vec[gi] = i_live[gi] & (w_entry_addr == i_squash_addr);
    end
  endgenerate

  assign o_enq_hit   = |w_enq_vec;
  assign o_probe_hit = |w_probe_vec;

  // Walk from oldest (tail-DEPTH) to youngest (tail-1); the last match written wins.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    v_idx       = '0;
    o_enq_idx   = '0;
    o_probe_idx = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      v_idx = i_tail - PTR_W'(k);
      if (w_enq_vec[v_idx])   o_enq_idx   = v_idx;
      if (w_probe_vec[v_idx]) o_probe_idx = v_idx;
    end
  end

endmodule

// File: rtl/l15_vc_evict_buffer.sv
// Eviction FIFO between the L1.5 S3 eviction path and the victim-cache fill port,
// with same-line merging, S1 probing and refill squashing of queued copies.
module l15_vc_evict_buffer
  import l15_vc_evict_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = VC_ADDR_WIDTH,
  parameter int DATA_WIDTH = L15_CACHELINE_WIDTH,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enq_val,
  input  logic [ADDR_WIDTH-1:0] i_enq_addr,
  input  logic [DATA_WIDTH-1:0] i_enq_data,
  input  logic                  i_enq_dirty,
  output logic                  o_enq_rdy,
  output logic                  o_vc_val,
  output logic [ADDR_WIDTH-1:0] o_vc_addr,
  output logic [DATA_WIDTH-1:0] o_vc_data,
  output logic [1:0]            o_vc_mesi,
  input  logic                  i_vc_rdy,
  input  logic [ADDR_WIDTH-1:0] i_probe_addr,
  output logic                  o_probe_hit,
  output logic [DATA_WIDTH-1:0] o_probe_data,
  output logic                  o_probe_dirty,
  input  logic                  i_squash_val,
  input  logic [ADDR_WIDTH-1:0] i_squash_addr,
  output logic [PTR_W:0]        o_occupancy
);

  localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_squashed;
  logic [DEPTH-1:0]      r_dirty;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [PTR_W:0]        r_count;

  logic [DEPTH*ADDR_WIDTH-1:0] w_addr_flat;
  logic [DEPTH-1:0]            w_live;
  logic [DEPTH-1:0]            w_fire_mask;
  logic [DEPTH-1:0]            w_squash_vec;
  logic [DEPTH-1:0]            w_wr_new;
  logic [DEPTH-1:0]            w_wr_merge;
  logic [DEPTH-1:0]            w_retire_here;
  logic [DEPTH-1:0]            w_sq_here;
  logic                        w_fire;
  logic                        w_auto_retire;
  logic                        w_retire;
  logic                        w_enq_hit;
  logic [PTR_W-1:0]            w_enq_idx;
  logic                        w_probe_hit;
  logic [PTR_W-1:0]            w_probe_idx;
  logic                        w_enq_fire;
  logic                        w_merge;
  logic                        w_alloc;

  assign w_live        = r_valid & ~r_squashed;
  assign o_vc_val      = w_live[r_head];
  assign w_fire        = o_vc_val & i_vc_rdy;
  assign w_auto_retire = r_valid[r_head] & r_squashed[r_head];
  assign w_retire      = w_fire | w_auto_retire;
  // A head that fires is already handed off: it neither merges nor gets squashed.
  assign w_fire_mask   = w_fire ? (DEPTH'(1) << r_head) : '0;

  assign o_enq_rdy  = (r_count != L_FULL) | w_enq_hit;
  assign w_enq_fire = i_enq_val & o_enq_rdy;
  assign w_merge    = w_enq_fire & w_enq_hit;
  assign w_alloc    = w_enq_fire & ~w_enq_hit;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign w_addr_flat[gi*ADDR_WIDTH +: ADDR_WIDTH] = r_addr[gi];
      assign w_wr_new[gi]      = w_alloc & (r_tail == PTR_W'(gi));
      assign w_wr_merge[gi]    = w_merge & (w_enq_idx == PTR_W'(gi));
      assign w_retire_here[gi] = w_retire & (r_head == PTR_W'(gi));
      // An enq of the same line in the same cycle overrides the squash.
      assign w_sq_here[gi]     = i_squash_val & w_squash_vec[gi] & ~w_fire_mask[gi] & ~w_wr_merge[gi];
    end
  endgenerate

  l15_vc_evict_cam #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_cam (
    .i_addr_flat   (w_addr_flat),
    .i_live        (w_live),
    .i_enq_excl    (w_fire_mask),
    .i_tail        (r_tail),
    .i_enq_addr    (i_enq_addr),
    .i_probe_addr  (i_probe_addr),
    .i_squash_addr (i_squash_addr),
    .o_enq_hit     (w_enq_hit),
    .o_enq_idx     (w_enq_idx),
    .o_probe_hit   (w_probe_hit),
    .o_probe_idx   (w_probe_idx),
    .o_squash_vec  (w_squash_vec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= '0;
      r_squashed <= '0;
      r_dirty    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_new[i]) begin
          r_valid[i]    <= 1'b1;
          r_squashed[i] <= 1'b0;
          r_dirty[i]    <= i_enq_dirty;
        end else begin
          if (w_retire_here[i]) r_valid[i]    <= 1'b0;
          if (w_sq_here[i])     r_squashed[i] <= 1'b1;
          if (w_wr_merge[i])    r_dirty[i]    <= r_dirty[i] | i_enq_dirty;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wr_new[i] | w_wr_merge[i]) r_data[i] <= i_enq_data;
      if (w_wr_new[i])                 r_addr[i] <= i_enq_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_retire) r_head <= r_head + PTR_W'(1);
      if (w_alloc)  r_tail <= r_tail + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_alloc) - (PTR_W+1)'(w_retire);
    end
  end

  assign o_vc_addr     = r_addr[r_head];
  assign o_vc_data     = r_data[r_head];
  assign o_vc_mesi     = evict_mesi(r_dirty[r_head]);
  assign o_probe_hit   = w_probe_hit;
  assign o_probe_data  = w_probe_hit ? r_data[w_probe_idx] : '0;
  assign o_probe_dirty = w_probe_hit & r_dirty[w_probe_idx];
  assign o_occupancy   = r_count;

  a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= L_FULL);
  a_enq_rdy_when_space: assert property (@(posedge clk) disable iff (rst)
    !(i_enq_val && !o_enq_rdy && (r_count < L_FULL)));

endmodule

// File: tb/tb_l15_vc_evict_buffer.sv
// Directed bench for l15_vc_evict_buffer: a table of per-cycle vectors plus a
// hand-written reset-mid-drain sequence.
module tb_l15_vc_evict_buffer;

  localparam int AW = 36;
  localparam int DW = 128;
  localparam logic [DW-1:0] Z  = '0;
  localparam logic [1:0]    ME = 2'b10;
  localparam logic [1:0]    MM = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          enq_val;
  logic [AW-1:0] enq_addr;
  logic [DW-1:0] enq_data;
  logic          enq_dirty;
  logic          enq_rdy;
  logic          vc_val;
  logic [AW-1:0] vc_addr;
  logic [DW-1:0] vc_data;
  logic [1:0]    vc_mesi;
  logic          vc_rdy;
  logic [AW-1:0] probe_addr;
  logic          probe_hit;
  logic [DW-1:0] probe_data;
  logic          probe_dirty;
  logic          squash_val;
  logic [AW-1:0] squash_addr;
  logic [2:0]    occupancy;

  always #5 clk = ~clk;

  l15_vc_evict_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .i_enq_val     (enq_val),
    .i_enq_addr    (enq_addr),
    .i_enq_data    (enq_data),
    .i_enq_dirty   (enq_dirty),
    .o_enq_rdy     (enq_rdy),
    .o_vc_val      (vc_val),
    .o_vc_addr     (vc_addr),
    .o_vc_data     (vc_data),
    .o_vc_mesi     (vc_mesi),
    .i_vc_rdy      (vc_rdy),
    .i_probe_addr  (probe_addr),
    .o_probe_hit   (probe_hit),
    .o_probe_data  (probe_data),
    .o_probe_dirty (probe_dirty),
    .i_squash_val  (squash_val),
    .i_squash_addr (squash_addr),
    .o_occupancy   (occupancy)
  );

  typedef struct {
    logic          enq_val;
    logic [AW-1:0] enq_addr;
    logic [DW-1:0] enq_data;
    logic          enq_dirty;
    logic          vc_rdy;
    logic [AW-1:0] probe_addr;
    logic          sq_val;
    logic [AW-1:0] sq_addr;
    logic          x_enq_rdy;
    logic          x_vc_val;
    logic [AW-1:0] x_vc_addr;
    logic [DW-1:0] x_vc_data;
    logic [1:0]    x_mesi;
    logic          x_phit;
    logic [DW-1:0] x_pdata;
    logic          x_pdirty;
    logic [2:0]    x_occ;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [DW-1:0] dat(input int k);
    return {4{32'hDA7A_0000 + 32'(k)}};
  endfunction

  function automatic vec_t mk(input int ev, input int ea, input logic [DW-1:0] ed, input int edty,
                              input int vr, input int pa, input int sv, input int sa,
                              input int xr, input int xv, input int xa, input logic [DW-1:0] xd,
                              input logic [1:0] xm, input int xph, input logic [DW-1:0] xpd,
                              input int xpdty, input int xocc);
    vec_t v;
    v.enq_val    = 1'(ev);
    v.enq_addr   = AW'(ea);
    v.enq_data   = ed;
    v.enq_dirty  = 1'(edty);
    v.vc_rdy     = 1'(vr);
    v.probe_addr = AW'(pa);
    v.sq_val     = 1'(sv);
    v.sq_addr    = AW'(sa);
    v.x_enq_rdy  = 1'(xr);
    v.x_vc_val   = 1'(xv);
    v.x_vc_addr  = AW'(xa);
    v.x_vc_data  = xd;
    v.x_mesi     = xm;
    v.x_phit     = 1'(xph);
    v.x_pdata    = xpd;
    v.x_pdirty   = 1'(xpdty);
    v.x_occ      = 3'(xocc);
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    enq_val     = 1'b0;
    enq_addr    = '0;
    enq_data    = '0;
    enq_dirty   = 1'b0;
    vc_rdy      = 1'b0;
    probe_addr  = '0;
    squash_val  = 1'b0;
    squash_addr = '0;
  endtask

  task automatic apply(input vec_t v);
    enq_val     = v.enq_val;
    enq_addr    = v.enq_addr;
    enq_data    = v.enq_data;
    enq_dirty   = v.enq_dirty;
    vc_rdy      = v.vc_rdy;
    probe_addr  = v.probe_addr;
    squash_val  = v.sq_val;
    squash_addr = v.sq_addr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Empty: single enq drains after one cycle
    vecs.push_back(mk(1, 1, dat(1), 0, 1, 1, 0, 0,  1, 0, 0, Z, ME, 0, Z, 0, 0));
    vecs.push_back(mk(0, 0, Z, 0, 1, 1, 0, 0,       1, 1, 1, dat(1), ME, 1, dat(1), 0, 1));
    vecs.push_back(mk(0, 0, Z, 0, 0, 1, 0, 0,       1, 0, 0, Z, ME, 0, Z, 0, 0));
    // Fill to full, reject new addr, merge dirty into 0x3
    vecs.push_back(mk(1, 1, dat(11), 0, 0, 0, 0, 0, 1, 0, 0, Z, ME, 0, Z, 0, 0));
    vecs.push_back(mk(1, 2, dat(12), 0, 0, 0, 0, 0, 1, 1, 1, dat(11), ME, 0, Z, 0, 1));
    vecs.push_back(mk(1, 3, dat(13), 0, 0, 0, 0, 0, 1, 1, 1, dat(11), ME, 0, Z, 0, 2));
    vecs.push_back(mk(1, 4, dat(14), 0, 0, 0, 0, 0, 1, 1, 1, dat(11), ME, 0, Z, 0, 3));
    vecs.push_back(mk(1, 5, dat(15), 0, 0, 0, 0, 0, 0, 1, 1, dat(11), ME, 0, Z, 0, 4));
    vecs.push_back(mk(1, 3, dat(23), 1, 0, 3, 0, 0, 1, 1, 1, dat(11), ME, 1, dat(13), 0, 4));
    vecs.push_back(mk(0, 0, Z, 0, 0, 3, 0, 0,       0, 1, 1, dat(11), ME, 1, dat(23), 1, 4));
    // Full with vc_rdy=1: refused this cycle, accepted the next
    vecs.push_back(mk(1, 5, dat(15), 0, 1, 0, 0, 0, 0, 1, 1, dat(11), ME, 0, Z, 0, 4));
    vecs.push_back(mk(1, 5, dat(15), 0, 1, 0, 0, 0, 1, 1, 2, dat(12), ME, 0, Z, 0, 3));
    vecs.push_back(mk(0, 0, Z, 0, 1, 5, 0, 0,       1, 1, 3, dat(23), MM, 1, dat(15), 0, 3));
    vecs.push_back(mk(0, 0, Z, 0, 1, 0, 0, 0,       1, 1, 4, dat(14), ME, 0, Z, 0, 2));
    vecs.push_back(mk(0, 0, Z, 0, 1, 0, 0, 0,       1, 1, 5, dat(15), ME, 0, Z, 0, 1));
    vecs.push_back(mk(0, 0, Z, 0, 0, 5, 0, 0,       1, 0, 0, Z, ME, 0, Z, 0, 0));
    // Queue {0x1,0x2}; probe hit/miss; squash head, it auto-retires silently
    vecs.push_back(mk(1, 1, dat(31), 0, 0, 0, 0, 0, 1, 0, 0, Z, ME, 0, Z, 0, 0));
    vecs.push_back(mk(1, 2, dat(32), 0, 0, 0, 0, 0, 1, 1, 1, dat(31), ME, 0, Z, 0, 1));
    vecs.push_back(mk(0, 0, Z, 0, 0, 2, 0, 0,       1, 1, 1, dat(31), ME, 1, dat(32), 0, 2));
    vecs.push_back(mk(0, 0, Z, 0, 0, 9, 1, 1,       1, 1, 1, dat(31), ME, 0, Z, 0, 2));
    vecs.push_back(mk(0, 0, Z, 0, 1, 1, 0, 0,       1, 0, 0, Z, ME, 0, Z, 0, 2));
    vecs.push_back(mk(0, 0, Z, 0, 1, 1, 0, 0,       1, 1, 2, dat(32), ME, 0, Z, 0, 1));
    vecs.push_back(mk(0, 0, Z, 0, 0, 2, 0, 0,       1, 0, 0, Z, ME, 0, Z, 0, 0));
    // Firing head 0x1 plus enq 0x1 in the same cycle allocates a new entry
    vecs.push_back(mk(1, 1, dat(41), 0, 0, 0, 0, 0, 1, 0, 0, Z, ME, 0, Z, 0, 0));
    vecs.push_back(mk(1, 1, dat(42), 0, 1, 1, 0, 0, 1, 1, 1, dat(41), ME, 1, dat(41), 0, 1));
    vecs.push_back(mk(0, 0, Z, 0, 1, 1, 0, 0,       1, 1, 1, dat(42), ME, 1, dat(42), 0, 1));
    vecs.push_back(mk(0, 0, Z, 0, 0, 1, 0, 0,       1, 0, 0, Z, ME, 0, Z, 0, 0));
    // Squash and merge-enq of the same line in one cycle: the enq wins
    vecs.push_back(mk(1, 7, dat(51), 0, 0, 0, 0, 0, 1, 0, 0, Z, ME, 0, Z, 0, 0));
    vecs.push_back(mk(1, 7, dat(52), 0, 0, 7, 1, 7, 1, 1, 7, dat(51), ME, 1, dat(51), 0, 1));
    vecs.push_back(mk(0, 0, Z, 0, 1, 7, 0, 0,       1, 1, 7, dat(52), ME, 1, dat(52), 0, 1));
    vecs.push_back(mk(0, 0, Z, 0, 0, 7, 0, 0,       1, 0, 0, Z, ME, 0, Z, 0, 0));

    set_idle();
    rst = 1'b1;
    #12;
    chk("reset_vc_val", DW'(vc_val), DW'(1'b0));
    chk("reset_enq_rdy", DW'(enq_rdy), DW'(1'b1));
    chk("reset_probe_hit", DW'(probe_hit), DW'(1'b0));
    chk("reset_occupancy", DW'(occupancy), DW'(3'd0));
    $display("reset: vc_val=%b enq_rdy=%b probe_hit=%b occ=%0d", vc_val, enq_rdy, probe_hit, occupancy);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      #3;
      $display("vec %0d: enq=%b addr=%h dirty=%b vc_rdy=%b probe=%h squash=%b/%h -> enq_rdy=%b vc_val=%b vc_addr=%h mesi=%b hit=%b pdirty=%b occ=%0d",
               i, enq_val, enq_addr, enq_dirty, vc_rdy, probe_addr, squash_val, squash_addr,
               enq_rdy, vc_val, vc_addr, vc_mesi, probe_hit, probe_dirty, occupancy);
      chk($sformatf("v%0d_enq_rdy", i), DW'(enq_rdy), DW'(vecs[i].x_enq_rdy));
      chk($sformatf("v%0d_vc_val", i), DW'(vc_val), DW'(vecs[i].x_vc_val));
      chk($sformatf("v%0d_occupancy", i), DW'(occupancy), DW'(vecs[i].x_occ));
      chk($sformatf("v%0d_probe_hit", i), DW'(probe_hit), DW'(vecs[i].x_phit));
      chk($sformatf("v%0d_probe_data", i), probe_data, vecs[i].x_pdata);
      if (vecs[i].x_vc_val) begin
        chk($sformatf("v%0d_vc_addr", i), DW'(vc_addr), DW'(vecs[i].x_vc_addr));
        chk($sformatf("v%0d_vc_data", i), vc_data, vecs[i].x_vc_data);
        chk($sformatf("v%0d_vc_mesi", i), DW'(vc_mesi), DW'(vecs[i].x_mesi));
      end
      if (vecs[i].x_phit) chk($sformatf("v%0d_probe_dirty", i), DW'(probe_dirty), DW'(vecs[i].x_pdirty));
      next_cycle();
    end

    // Reset asserted asynchronously mid-drain with three entries queued
    set_idle();
    for (int k = 0; k < 3; k++) begin
      enq_val  = 1'b1;
      enq_addr = AW'(32'h21 + k);
      enq_data = dat(60 + k);
      $display("fill: enq addr=%h", enq_addr);
      next_cycle();
    end
    set_idle();
    vc_rdy     = 1'b1;
    probe_addr = AW'(32'h22);
    #2;
    chk("pre_rst_occupancy", DW'(occupancy), DW'(3'd3));
    chk("pre_rst_vc_val", DW'(vc_val), DW'(1'b1));
    rst = 1'b1;
    #1;
    $display("async rst: vc_val=%b occ=%0d enq_rdy=%b probe_hit=%b", vc_val, occupancy, enq_rdy, probe_hit);
    chk("rst_mid_vc_val", DW'(vc_val), DW'(1'b0));
    chk("rst_mid_occupancy", DW'(occupancy), DW'(3'd0));
    chk("rst_mid_enq_rdy", DW'(enq_rdy), DW'(1'b1));
    chk("rst_mid_probe_hit", DW'(probe_hit), DW'(1'b0));
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      $display("post-rst %0d: vc_val=%b occ=%0d", k, vc_val, occupancy);
      chk($sformatf("post_rst%0d_vc_val", k), DW'(vc_val), DW'(1'b0));
      chk($sformatf("post_rst%0d_occupancy", k), DW'(occupancy), DW'(3'd0));
      next_cycle();
    end
    vc_rdy   = 1'b0;
    enq_val  = 1'b1;
    enq_addr = AW'(32'h30);
    enq_data = dat(70);
    next_cycle();
    set_idle();
    #3;
    $display("after rst enq: vc_val=%b vc_addr=%h occ=%0d", vc_val, vc_addr, occupancy);
    chk("post_rst_enq_vc_val", DW'(vc_val), DW'(1'b1));
    chk("post_rst_enq_vc_addr", DW'(vc_addr), DW'(AW'(32'h30)));
    chk("post_rst_enq_vc_data", vc_data, dat(70));
    chk("post_rst_enq_occupancy", DW'(occupancy), DW'(3'd1));
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
